note_lane_engine: RTL and testbench
===================================

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent falling-note lanes (1..8).
REQ-002 SHALL have parameter LANE_PITCH, default 80: x spacing in pixels; lane i left edge = i*LANE_PITCH.
REQ-003 SHALL have parameter SPRITE_W, default 50: sprite width in pixels.
REQ-004 SHALL have parameter SPRITE_H, default 50: sprite height in pixels.
REQ-005 SHALL have parameter SCREEN_H, default 480: visible line count.
REQ-006 SHALL have parameter SPEED, default 2: pixels advanced per frame_tick (1..15).
REQ-007 SHALL have parameters HIT_Y, default 400, and HIT_WIN, default 16: strike window is lane_y in [HIT_Y-HIT_WIN, HIT_Y+HIT_WIN].
REQ-008 SHALL have port clk  in  1  system clock; one clock, all state on its rising edge.
REQ-009 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-010 SHALL have port frame_tick  in  1  one-cycle pulse between frames (screenEnd).
REQ-011 SHALL have ports x  in  10 and y  in  9: current pixel coordinate.
REQ-012 SHALL have port spawn  in  LANES  per-lane note start request, level-sampled.
REQ-013 SHALL have port strike  in  LANES  per-lane player strike, one-cycle pulse.
REQ-014 SHALL have port in_bounds  out  1  current pixel covered by a visible sprite.
REQ-015 SHALL have port sprite_addr  out  $clog2(SPRITE_W*SPRITE_H)  sprite ROM address.
REQ-016 SHALL have ports hit_pulse and miss_pulse  out  LANES  one-cycle scoring events.
REQ-017 SHALL have port lane_busy  out  LANES  lane state != IDLE.

Function
REQ-018 Each lane SHALL run FSM IDLE -> FALL -> (HIT -> IDLE | IDLE); lane_y is 10-bit unsigned.
REQ-019 IDLE: spawn[i]=1 SHALL enter FALL with lane_y=0 next cycle; spawn in FALL or HIT SHALL be ignored.
REQ-020 FALL: on frame_tick lane_y SHALL add SPEED; if lane_y+SPEED >= SCREEN_H, lane SHALL go IDLE, lane_y=0, miss_pulse[i]=1 for one cycle.
REQ-021 FALL: strike[i] with lane_y inside window SHALL enter HIT and assert hit_pulse[i] one cycle; strike outside window SHALL be ignored.
REQ-022 strike and frame_tick in the same cycle SHALL evaluate strike against pre-update lane_y; hit takes priority over bottom-exit miss.
REQ-023 HIT: lane_y SHALL freeze; 8-frame counter SHALL count frame_ticks, then IDLE; sprite stays visible during HIT.
REQ-024 Compositor SHALL flag a lane covering (x,y) when lane busy, x-left in [0,SPRITE_W), y-lane_y in [0,SPRITE_H) (inclusive top/left, exclusive bottom/right).
REQ-025 Overlap SHALL resolve to lowest lane index.
REQ-026 sprite_addr SHALL equal (x-left)+(y-lane_y)*SPRITE_W for the winning lane, else 0.
REQ-027 in_bounds and sprite_addr SHALL be registered, latency exactly 1 clk from x,y.
REQ-028 Sprites extending past SCREEN_H SHALL be clipped by the y compare only; no wrap to top.

Reset
REQ-029 reset low SHALL immediately force all lanes IDLE, lane_y=0, HIT counters 0, in_bounds=0, sprite_addr=0, hit_pulse=0, miss_pulse=0, lane_busy=0.
REQ-030 Reset asserted mid-FALL SHALL drop the note without miss_pulse; first spawn after release is honoured normally.

Configuration
REQ-031 Macro NOTE_LANE_AUTOSPAWN_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) SHALL step each frame_tick; every 32nd frame_tick an internal spawn SHALL target lane lfsr[2:0] mod LANES, ORed with port spawn.
REQ-032 Macro undefined: no LFSR or auto-spawn logic; lanes start only from spawn port.

Verification
REQ-033 Reset, spawn[0]=1 one cycle, 10 frame_ticks -> lane_busy[0]=1, lane_y[0]=20, x=5,y=25 gives in_bounds=1, sprite_addr=255 next clk.
REQ-034 Lane 1 falls to lane_y=400, strike[1] pulse -> hit_pulse[1]=1 one cycle; 8 frame_ticks later lane_busy[1]=0.
REQ-035 Lane 2 never struck, SCREEN_H=480, SPEED=2 -> miss_pulse[2] after 240th frame_tick, lane_busy[2]=0.
REQ-036 strike[3] at lane_y=100 -> no hit_pulse, lane continues; strike coincident with frame_tick at lane_y=384 -> hit_pulse, lane_y stays 384.
REQ-037 LANE_PITCH=30, lanes 0 and 1 at equal lane_y, x=35 -> sprite_addr from lane 0 (x-0=35).
REQ-038 reset pulsed low during FALL -> all outputs 0 asynchronously, no miss_pulse after release.

Source files
------------

// File: rtl/note_lane_engine.sv
// ----------------------------------------------------------------------------
// note_lane_engine
//
// Purpose:
//   Runs LANES independent falling-note lanes for a rhythm-game display.
//   Each lane is a small FSM (IDLE -> FALL -> HIT -> IDLE, or FALL -> IDLE on
//   a miss) holding a 10-bit vertical position. A pixel compositor reports
//   whether the current raster pixel (x,y) lies on a visible sprite and, if
//   so, the sprite ROM address for that pixel. Overlapping sprites resolve to
//   the lowest lane index.
//
// Ports:
//   clk          in   1        system clock, all state on rising edge
//   reset        in   1        asynchronous, active-low reset
//   frame_tick   in   1        one-cycle pulse between frames
//   x            in   10       current pixel column
//   y            in   9        current pixel row
//   spawn        in   LANES    per-lane note start request (level-sampled)
//   strike       in   LANES    per-lane player strike pulse
//   in_bounds    out  1        pixel covered by a visible sprite (1 clk latency)
//   sprite_addr  out  ADDR_W   sprite ROM address (1 clk latency), else 0
//   hit_pulse    out  LANES    one-cycle hit event
//   miss_pulse   out  LANES    one-cycle miss event
//   lane_busy    out  LANES    lane is not IDLE
//
// Configuration:
//   NOTE_LANE_AUTOSPAWN_EN  when defined, a 16-bit LFSR stepped on each
//                           frame_tick launches a note on lane lfsr[2:0] mod
//                           LANES every 32nd frame_tick, ORed with spawn.
// ----------------------------------------------------------------------------
module note_lane_engine #(
    parameter int LANES      = 4,
    parameter int LANE_PITCH = 80,
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 50,
    parameter int SCREEN_H   = 480,
    parameter int SPEED      = 2,
    parameter int HIT_Y      = 400,
    parameter int HIT_WIN    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_tick,
    input  logic [9:0]                           x,
    input  logic [8:0]                           y,
    input  logic [LANES-1:0]                     spawn,
    input  logic [LANES-1:0]                     strike,
    output logic                                 in_bounds,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] sprite_addr,
    output logic [LANES-1:0]                     hit_pulse,
    output logic [LANES-1:0]                     miss_pulse,
    output logic [LANES-1:0]                     lane_busy
);

    localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        HIT  = 2'd2
    } laneState_t;

    laneState_t        r_state   [LANES];
    logic [9:0]        r_laneY   [LANES];
    logic [2:0]        r_hitCnt  [LANES];
    logic              r_inBounds;
    logic [ADDR_W-1:0] r_spriteAddr;
    logic [LANES-1:0]  r_hitPulse;
    logic [LANES-1:0]  r_missPulse;

    laneState_t        w_nextState [LANES];
    logic [9:0]        w_nextY     [LANES];
    logic [2:0]        w_nextCnt   [LANES];
    logic [10:0]       w_sum       [LANES];
    logic [LANES-1:0]  w_hit;
    logic [LANES-1:0]  w_miss;
    logic [LANES-1:0]  w_spawn;
    int                w_dx        [LANES];
    int                w_dy        [LANES];
    logic              w_inBounds;
    logic [ADDR_W-1:0] w_spriteAddr;

`ifdef NOTE_LANE_AUTOSPAWN_EN
    logic [15:0]      r_lfsr;
    logic [4:0]       r_tickCnt;
    logic [LANES-1:0] w_autoSpawn;

    // Fibonacci LFSR (taps 16,14,13,11) plus a frame counter; both advance
    // only on frame_tick so auto-spawns are paced in frames, not clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr    <= 16'hACE1;
            r_tickCnt <= '0;
        end else if (frame_tick) begin
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_tickCnt <= r_tickCnt + 5'd1;
        end
    end

    // The 32nd frame_tick of each group fires one internal spawn request on
    // the lane selected by the low LFSR bits.
    always_comb begin
        w_autoSpawn = '0;
        for (int i = 0; i < LANES; i++) begin
            if (frame_tick && (r_tickCnt == 5'd31) && ((int'(r_lfsr[2:0]) % LANES) == i)) begin
                w_autoSpawn[i] = 1'b1;
            end
        end
    end

    assign w_spawn = spawn | w_autoSpawn;
`else
    assign w_spawn = spawn;
`endif

    // Per-lane next-state logic. A valid strike is judged on the position
    // held before this cycle's frame advance and beats a bottom-exit miss.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_nextState[i] = r_state[i];
            w_nextY[i]     = r_laneY[i];
            w_nextCnt[i]   = r_hitCnt[i];
            w_sum[i]       = {1'b0, r_laneY[i]} + 11'(SPEED);
            w_hit[i]       = 1'b0;
            w_miss[i]      = 1'b0;
            case (r_state[i])
                IDLE: begin
                    if (w_spawn[i]) begin
                        w_nextState[i] = FALL;
                        w_nextY[i]     = '0;
                    end
                end
                FALL: begin
                    if (strike[i] && (int'(r_laneY[i]) >= HIT_Y - HIT_WIN)
                                  && (int'(r_laneY[i]) <= HIT_Y + HIT_WIN)) begin
                        w_nextState[i] = HIT;
                        w_nextCnt[i]   = '0;
                        w_hit[i]       = 1'b1;
                    end else if (frame_tick) begin
                        if (w_sum[i] >= 11'(SCREEN_H)) begin
                            w_nextState[i] = IDLE;
                            w_nextY[i]     = '0;
                            w_miss[i]      = 1'b1;
                        end else begin
                            w_nextY[i] = w_sum[i][9:0];
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (r_hitCnt[i] == 3'd7) begin
                            w_nextState[i] = IDLE;
                            w_nextY[i]     = '0;
                            w_nextCnt[i]   = '0;
                        end else begin
                            w_nextCnt[i] = r_hitCnt[i] + 3'd1;
                        end
                    end
                end
                default: begin
                    w_nextState[i] = IDLE;
                    w_nextY[i]     = '0;
                    w_nextCnt[i]   = '0;
                end
            endcase
        end
    end

    // Pixel offsets of (x,y) relative to each lane's sprite origin; negative
    // values mean the pixel is above/left of the sprite.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_dx[i] = int'(x) - i * LANE_PITCH;
            w_dy[i] = int'(y) - int'(r_laneY[i]);
        end
    end

    // Walk from the highest lane down so the lowest covering lane wins.
    always_comb begin
        w_inBounds   = 1'b0;
        w_spriteAddr = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if ((r_state[i] != IDLE) && (w_dx[i] >= 0) && (w_dx[i] < SPRITE_W)
                                     && (w_dy[i] >= 0) && (w_dy[i] < SPRITE_H)) begin
                w_inBounds   = 1'b1;
                w_spriteAddr = ADDR_W'(w_dx[i] + w_dy[i] * SPRITE_W);
            end
        end
    end

    // State, position, counters and the registered compositor/event outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i]  <= IDLE;
                r_laneY[i]  <= '0;
                r_hitCnt[i] <= '0;
            end
            r_inBounds   <= 1'b0;
            r_spriteAddr <= '0;
            r_hitPulse   <= '0;
            r_missPulse  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_state[i]  <= w_nextState[i];
                r_laneY[i]  <= w_nextY[i];
                r_hitCnt[i] <= w_nextCnt[i];
            end
            r_inBounds   <= w_inBounds;
            r_spriteAddr <= w_spriteAddr;
            r_hitPulse   <= w_hit;
            r_missPulse  <= w_miss;
        end
    end

    // Busy flags come straight from the state registers.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_busy[i] = (r_state[i] != IDLE);
        end
    end

    assign in_bounds   = r_inBounds;
    assign sprite_addr = r_spriteAddr;
    assign hit_pulse   = r_hitPulse;
    assign miss_pulse  = r_missPulse;

endmodule

// File: tb/tb_note_lane_engine.sv
// ----------------------------------------------------------------------------
// tb_note_lane_engine
//
// Self-checking bench for note_lane_engine. A lane-level behavioural model
// (mode, position, frames-since-hit per lane) predicts pulses, busy flags and
// the compositor result. LANE_PITCH is 30 so neighbouring sprites overlap.
// ----------------------------------------------------------------------------
module tb_note_lane_engine;

    localparam int LANES = 4;
    localparam int PITCH = 30;
    localparam int SW    = 50;
    localparam int SH    = 50;
    localparam int SCR   = 480;
    localparam int SPD   = 2;
    localparam int HY    = 400;
    localparam int HW    = 16;
    localparam int AW    = $clog2(SW*SH);

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic             frame_tick = 1'b0;
    logic [9:0]       x          = '0;
    logic [8:0]       y          = '0;
    logic [LANES-1:0] spawn      = '0;
    logic [LANES-1:0] strike     = '0;
    logic             in_bounds;
    logic [AW-1:0]    sprite_addr;
    logic [LANES-1:0] hit_pulse;
    logic [LANES-1:0] miss_pulse;
    logic [LANES-1:0] lane_busy;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: mode 0 = idle, 1 = falling, 2 = struck
    int               mMode  [LANES];
    int               mY     [LANES];
    int               mTicks [LANES];
    logic             eIn;
    int               eAddr;
    logic [LANES-1:0] eHit;
    logic [LANES-1:0] eMiss;
    logic [LANES-1:0] eBusy;

    note_lane_engine #(
        .LANES      (LANES),
        .LANE_PITCH (PITCH),
        .SPRITE_W   (SW),
        .SPRITE_H   (SH),
        .SCREEN_H   (SCR),
        .SPEED      (SPD),
        .HIT_Y      (HY),
        .HIT_WIN    (HW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .x           (x),
        .y           (y),
        .spawn       (spawn),
        .strike      (strike),
        .in_bounds   (in_bounds),
        .sprite_addr (sprite_addr),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .lane_busy   (lane_busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Clear the model to its power-on picture
    task automatic modelReset();
        for (int i = 0; i < LANES; i++) begin
            mMode[i]  = 0;
            mY[i]     = 0;
            mTicks[i] = 0;
        end
        eIn   = 1'b0;
        eAddr = 0;
        eHit  = '0;
        eMiss = '0;
        eBusy = '0;
    endtask

    // Hold reset for two edges, release just after an edge
    task automatic applyReset();
        reset = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Drive one clock of inputs and advance the model by the game rules
    task automatic applyStimulus(input logic ft, input logic [LANES-1:0] sp,
                                 input logic [LANES-1:0] st);
        int xi;
        int yi;
        frame_tick = ft;
        spawn      = sp;
        strike     = st;
        xi = int'(x);
        yi = int'(y);
        eIn   = 1'b0;
        eAddr = 0;
        for (int i = 0; i < LANES; i++) begin
            int left;
            left = i * PITCH;
            if (!eIn && mMode[i] != 0 && xi >= left && xi < left + SW
                     && yi >= mY[i] && yi < mY[i] + SH) begin
                eIn   = 1'b1;
                eAddr = (xi - left) + (yi - mY[i]) * SW;
            end
        end
        eHit  = '0;
        eMiss = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mMode[i] == 0) begin
                if (sp[i]) begin
                    mMode[i] = 1;
                    mY[i]    = 0;
                end
            end else if (mMode[i] == 1) begin
                if (st[i] && mY[i] >= HY - HW && mY[i] <= HY + HW) begin
                    mMode[i]  = 2;
                    mTicks[i] = 0;
                    eHit[i]   = 1'b1;
                end else if (ft) begin
                    if (mY[i] + SPD >= SCR) begin
                        mMode[i] = 0;
                        mY[i]    = 0;
                        eMiss[i] = 1'b1;
                    end else begin
                        mY[i] = mY[i] + SPD;
                    end
                end
            end else begin
                if (ft) begin
                    mTicks[i] = mTicks[i] + 1;
                    if (mTicks[i] == 8) begin
                        mMode[i]  = 0;
                        mY[i]     = 0;
                        mTicks[i] = 0;
                    end
                end
            end
            eBusy[i] = (mMode[i] != 0);
        end
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        spawn      = '0;
        strike     = '0;
    endtask

    // n frames, each a tick cycle followed by a quiet cycle
    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, '0, '0);
            applyStimulus(1'b0, '0, '0);
        end
    endtask

    // Outputs while reset is held low
    task automatic test_reset();
        reset = 1'b0;
        modelReset();
        #7;
        nCompared++;
        if (lane_busy !== '0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", lane_busy); end
        nCompared++;
        if (hit_pulse !== '0 || miss_pulse !== '0) begin nMismatched++; $display("[TB] FAIL reset_pulses: got hit %b miss %b expected 0", hit_pulse, miss_pulse); end
        nCompared++;
        if (in_bounds !== 1'b0 || sprite_addr !== '0) begin nMismatched++; $display("[TB] FAIL reset_comp: got in %b addr %0d expected 0/0", in_bounds, sprite_addr); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Spawn lane 0, 10 frames, probe the sprite at (5,25)
    task automatic test_spawn_fall();
        applyReset();
        x = 10'd1000;
        y = 9'd0;
        applyStimulus(1'b0, 4'b0001, '0);
        frames(10);
        x = 10'd5;
        y = 9'd25;
        applyStimulus(1'b0, '0, '0);
        nCompared++;
        if (lane_busy !== 4'b0001) begin nMismatched++; $display("[TB] FAIL spawn_busy: got %b expected 0001", lane_busy); end
        nCompared++;
        if (in_bounds !== 1'b1) begin nMismatched++; $display("[TB] FAIL spawn_inb: got %b expected 1", in_bounds); end
        nCompared++;
        if (sprite_addr !== AW'(255)) begin nMismatched++; $display("[TB] FAIL spawn_addr: got %0d expected 255", sprite_addr); end
        nCompared++;
        if (sprite_addr !== AW'(eAddr)) begin nMismatched++; $display("[TB] FAIL spawn_addr_model: got %0d expected %0d", sprite_addr, eAddr); end
        x = 10'd100;
        applyStimulus(1'b0, '0, '0);
        nCompared++;
        if (in_bounds !== 1'b0 || sprite_addr !== '0) begin nMismatched++; $display("[TB] FAIL spawn_outside: got in %b addr %0d expected 0/0", in_bounds, sprite_addr); end
    endtask

    // Lane 1 struck at 400, released after 8 frames
    task automatic test_hit();
        applyReset();
        applyStimulus(1'b0, 4'b0010, '0);
        frames(200);
        applyStimulus(1'b0, '0, 4'b0010);
        nCompared++;
        if (hit_pulse !== 4'b0010 || hit_pulse !== eHit) begin nMismatched++; $display("[TB] FAIL hit_pulse: got %b expected 0010", hit_pulse); end
        applyStimulus(1'b0, '0, '0);
        nCompared++;
        if (hit_pulse !== '0) begin nMismatched++; $display("[TB] FAIL hit_one_cycle: got %b expected 0000", hit_pulse); end
        frames(7);
        nCompared++;
        if (lane_busy !== 4'b0010) begin nMismatched++; $display("[TB] FAIL hit_hold7: got %b expected 0010", lane_busy); end
        frames(1);
        nCompared++;
        if (lane_busy !== 4'b0000 || lane_busy !== eBusy) begin nMismatched++; $display("[TB] FAIL hit_release8: got %b expected 0000", lane_busy); end
    endtask

    // Lane 2 never struck; miss exactly on the 240th frame tick
    task automatic test_miss();
        int missAt;
        missAt = -1;
        applyReset();
        applyStimulus(1'b0, 4'b0100, '0);
        for (int t = 1; t <= 240; t++) begin
            applyStimulus(1'b1, '0, '0);
            nCompared++;
            if (miss_pulse !== eMiss) begin nMismatched++; $display("[TB] FAIL miss_tick%0d: got %b expected %b", t, miss_pulse, eMiss); end
            if (miss_pulse[2] === 1'b1) missAt = t;
            applyStimulus(1'b0, '0, '0);
            nCompared++;
            if (miss_pulse !== '0) begin nMismatched++; $display("[TB] FAIL miss_quiet%0d: got %b expected 0000", t, miss_pulse); end
        end
        nCompared++;
        if (missAt !== 240) begin nMismatched++; $display("[TB] FAIL miss_when: got tick %0d expected 240", missAt); end
        nCompared++;
        if (lane_busy !== '0) begin nMismatched++; $display("[TB] FAIL miss_busy: got %b expected 0000", lane_busy); end
    endtask

    // Strike outside window ignored; strike with tick at 384 hits and freezes
    task automatic test_strike_window();
        applyReset();
        applyStimulus(1'b0, 4'b1000, '0);
        frames(50);
        applyStimulus(1'b0, '0, 4'b1000);
        nCompared++;
        if (hit_pulse !== '0 || lane_busy !== 4'b1000) begin nMismatched++; $display("[TB] FAIL strike_at100: got hit %b busy %b expected 0000/1000", hit_pulse, lane_busy); end
        frames(141);
        applyStimulus(1'b0, '0, 4'b1000);
        nCompared++;
        if (hit_pulse !== '0) begin nMismatched++; $display("[TB] FAIL strike_at382: got %b expected 0000", hit_pulse); end
        applyStimulus(1'b1, '0, '0);
        applyStimulus(1'b1, '0, 4'b1000);
        nCompared++;
        if (hit_pulse !== 4'b1000) begin nMismatched++; $display("[TB] FAIL strike_at384: got %b expected 1000", hit_pulse); end
        x = 10'd91;
        y = 9'd390;
        applyStimulus(1'b0, '0, '0);
        frames(3);
        nCompared++;
        if (in_bounds !== 1'b1 || sprite_addr !== AW'(301)) begin nMismatched++; $display("[TB] FAIL strike_frozen: got in %b addr %0d expected 1/301", in_bounds, sprite_addr); end
    endtask

    // Equal heights on lanes 0 and 1, pixel in both; lane 0 wins
    task automatic test_overlap();
        applyReset();
        applyStimulus(1'b0, 4'b0011, '0);
        frames(5);
        x = 10'd35;
        y = 9'd20;
        applyStimulus(1'b0, '0, '0);
        nCompared++;
        if (in_bounds !== 1'b1 || sprite_addr !== AW'(535)) begin nMismatched++; $display("[TB] FAIL overlap_addr: got in %b addr %0d expected 1/535", in_bounds, sprite_addr); end
        nCompared++;
        if (sprite_addr !== AW'(eAddr)) begin nMismatched++; $display("[TB] FAIL overlap_model: got %0d expected %0d", sprite_addr, eAddr); end
    endtask

    // Reset asserted mid-fall clears at once; no miss afterwards
    task automatic test_reset_midfall();
        applyReset();
        applyStimulus(1'b0, 4'b0001, '0);
        frames(20);
        x = 10'd10;
        y = 9'd45;
        applyStimulus(1'b0, '0, '0);
        nCompared++;
        if (in_bounds !== 1'b1 || lane_busy !== 4'b0001) begin nMismatched++; $display("[TB] FAIL midfall_pre: got in %b busy %b expected 1/0001", in_bounds, lane_busy); end
        #2 reset = 1'b0;
        #1;
        nCompared++;
        if (lane_busy !== '0 || in_bounds !== 1'b0 || sprite_addr !== '0) begin nMismatched++; $display("[TB] FAIL midfall_async: got busy %b in %b addr %0d expected 0", lane_busy, in_bounds, sprite_addr); end
        modelReset();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 250; k++) begin
            applyStimulus(1'b1, '0, '0);
            nCompared++;
            if (miss_pulse !== '0 || lane_busy !== '0) begin nMismatched++; $display("[TB] FAIL midfall_after%0d: got miss %b busy %b expected 0", k, miss_pulse, lane_busy); end
        end
        applyStimulus(1'b0, 4'b0001, '0);
        nCompared++;
        if (lane_busy !== 4'b0001) begin nMismatched++; $display("[TB] FAIL midfall_respawn: got %b expected 0001", lane_busy); end
    endtask

    // Random spawns, strikes, ticks and pixels near active sprites
    task automatic test_random();
        logic             ft;
        logic [LANES-1:0] sp;
        logic [LANES-1:0] st;
        int               k;
        int               xv;
        int               yv;
        applyReset();
        for (int c = 0; c < 4000; c++) begin
            ft = ($urandom % 2) == 0;
            sp = LANES'($urandom % 16);
            for (int i = 0; i < LANES; i++) st[i] = ($urandom % 8) == 0;
            k  = int'($urandom % LANES);
            xv = k * PITCH + int'($urandom_range(0, 54)) - 2;
            yv = mY[k] + int'($urandom_range(0, 54)) - 2;
            if (xv < 0) xv = 0;
            if (yv < 0) yv = 0;
            if (yv > 511) yv = 511;
            x = 10'(xv);
            y = 9'(yv);
            applyStimulus(ft, sp, st);
            nCompared++;
            if (hit_pulse !== eHit) begin nMismatched++; $display("[TB] FAIL rnd_hit c%0d: got %b expected %b", c, hit_pulse, eHit); end
            nCompared++;
            if (miss_pulse !== eMiss) begin nMismatched++; $display("[TB] FAIL rnd_miss c%0d: got %b expected %b", c, miss_pulse, eMiss); end
            nCompared++;
            if (lane_busy !== eBusy) begin nMismatched++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, lane_busy, eBusy); end
            nCompared++;
            if (in_bounds !== eIn || sprite_addr !== AW'(eAddr)) begin nMismatched++; $display("[TB] FAIL rnd_comp c%0d: got in %b addr %0d expected %b/%0d", c, in_bounds, sprite_addr, eIn, eAddr); end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_spawn_fall();
        test_hit();
        test_miss();
        test_strike_window();
        test_overlap();
        test_reset_midfall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
